// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the calculator keypad front end.
//   - key_class_t    : NONE / DIGIT / OP / CTRL
//   - OP_* / CTRL_*  : key_value encodings for operator and control keys
//   - decode_4x4()   : key index (row*4+col) -> class/value for the
//                      layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
package keypad_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2,
    CTRL  = 2'd3
  } key_class_t;

  localparam logic [3:0] OP_ADD      = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_MUL      = 4'd2;
  localparam logic [3:0] OP_DIV      = 4'd3;
  localparam logic [3:0] CTRL_CLEAR  = 4'd0;
  localparam logic [3:0] CTRL_EQUALS = 4'd1;

  typedef struct packed {
    key_class_t cls;
    logic [3:0] value;
  } key_decode_t;

  function automatic key_decode_t decode_4x4(input logic [3:0] code);
    key_decode_t d;
    d.cls   = NONE;
    d.value = 4'd0;
    case (code)
      4'd0:  begin d.cls = DIGIT; d.value = 4'd1;        end
      4'd1:  begin d.cls = DIGIT; d.value = 4'd2;        end
      4'd2:  begin d.cls = DIGIT; d.value = 4'd3;        end
      4'd3:  begin d.cls = OP;    d.value = OP_ADD;      end
      4'd4:  begin d.cls = DIGIT; d.value = 4'd4;        end
      4'd5:  begin d.cls = DIGIT; d.value = 4'd5;        end
      4'd6:  begin d.cls = DIGIT; d.value = 4'd6;        end
      4'd7:  begin d.cls = OP;    d.value = OP_SUB;      end
      4'd8:  begin d.cls = DIGIT; d.value = 4'd7;        end
      4'd9:  begin d.cls = DIGIT; d.value = 4'd8;        end
      4'd10: begin d.cls = DIGIT; d.value = 4'd9;        end
      4'd11: begin d.cls = OP;    d.value = OP_MUL;      end
      4'd12: begin d.cls = CTRL;  d.value = CTRL_CLEAR;  end
      4'd13: begin d.cls = DIGIT; d.value = 4'd0;        end
      4'd14: begin d.cls = CTRL;  d.value = CTRL_EQUALS; end
      default: begin d.cls = OP;  d.value = OP_DIV;      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync
//   Two-flop synchroniser for the asynchronous keypad row inputs.
//   Ports: clk, rst (async, active-high), din[WIDTH] raw, dout[WIDTH] synced.
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= din[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign dout = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Matrix keypad scanner with press/release debounce, optional auto-repeat
//   and calculator decode.
//   Ports: clk, rst (async, active-high), enable (low idles the block),
//          filas[ROWS] raw rows in, columnas[COLS] one-hot column drive,
//          key_valid strobe, key_code (row*COLS+col), key_class, key_value,
//          key_held (debounced key currently down).
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 0,
  localparam int CODE_W         = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ROWS-1:0]   filas,
  output logic [COLS-1:0]   columnas,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic [1:0]        key_class,
  output logic [3:0]        key_value,
  output logic              key_held
);

  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int DVW = $clog2(SCAN_DIV);
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DVW-1:0] DWELL_LAST = DVW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] REP_LAST   = RPW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [CW-1:0]  COL_LAST   = CW'(COLS - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HOLD, S_RELEASE} state_t;

  state_t            state_reg;
  logic [CW-1:0]     col_reg;
  logic [DVW-1:0]    dwell_reg;
  logic [DBW-1:0]    cnt_reg;    // shared by press debounce and release debounce
  logic [RPW-1:0]    rep_reg;
  logic [ROWS-1:0]   pat_reg;    // latched one-hot row pattern
  logic [RW-1:0]     row_reg;
  logic              key_valid_reg;
  logic              key_held_reg;
  logic [CODE_W-1:0] key_code_reg;
  key_class_t        key_class_reg;
  logic [3:0]        key_value_reg;

  logic [ROWS-1:0]   rs;
  logic              rs_onehot;
  logic [RW-1:0]     row_idx;
  logic [CW-1:0]     col_next;
  logic [CODE_W-1:0] code_next;
  key_decode_t       dec;

  keypad_row_sync #(.WIDTH(ROWS)) u_row_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (filas),
    .dout (rs)
  );

  assign rs_onehot = (rs != '0) && ((rs & (rs - ROWS'(1))) == '0);

  always_comb begin
    row_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (rs[i]) row_idx = RW'(i);
    end
  end

  assign col_next  = (col_reg == COL_LAST) ? '0 : col_reg + CW'(1);
  assign code_next = CODE_W'(row_reg) * CODE_W'(COLS) + CODE_W'(col_reg);

  always_comb begin
    dec.cls   = NONE;
    dec.value = 4'd0;
    if (ROWS == 4 && COLS == 4) dec = decode_4x4(4'(code_next));
  end

  // Gated directly by enable so the drive stops, and restarts on column 0,
  // in the very cycle enable changes.
  assign columnas = enable ? ({{(COLS-1){1'b0}}, 1'b1} << col_reg) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_SCAN;
      col_reg       <= '0;
      dwell_reg     <= '0;
      cnt_reg       <= '0;
      rep_reg       <= '0;
      pat_reg       <= '0;
      row_reg       <= '0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
      key_code_reg  <= '0;
      key_class_reg <= NONE;
      key_value_reg <= 4'd0;
    end else if (!enable) begin
      state_reg     <= S_SCAN;
      col_reg       <= '0;
      dwell_reg     <= '0;
      cnt_reg       <= '0;
      rep_reg       <= '0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      case (state_reg)
        S_SCAN: begin
          if (dwell_reg == DWELL_LAST) begin
            dwell_reg <= '0;
            if (rs_onehot) begin
              pat_reg   <= rs;
              row_reg   <= row_idx;
              cnt_reg   <= '0;
              state_reg <= S_DEBOUNCE;
            end else begin
              col_reg <= col_next;
            end
          end else begin
            dwell_reg <= dwell_reg + DVW'(1);
          end
        end
        S_DEBOUNCE: begin
          if (rs == pat_reg) begin
            if (cnt_reg == DEB_LAST) begin
              cnt_reg       <= '0;
              rep_reg       <= '0;
              key_valid_reg <= 1'b1;
              key_held_reg  <= 1'b1;
              key_code_reg  <= code_next;
              key_class_reg <= dec.cls;
              key_value_reg <= dec.value;
              state_reg     <= S_HOLD;
            end else begin
              cnt_reg <= cnt_reg + DBW'(1);
            end
          end else begin
            cnt_reg   <= '0;
            dwell_reg <= '0;
            col_reg   <= col_next;
            state_reg <= S_SCAN;
          end
        end
        S_HOLD: begin
          if (rs != pat_reg) begin
            cnt_reg   <= '0;
            state_reg <= S_RELEASE;
          end else if (REPEAT_CYCLES > 0) begin
            if (rep_reg == REP_LAST) begin
              rep_reg       <= '0;
              key_valid_reg <= 1'b1;
            end else begin
              rep_reg <= rep_reg + RPW'(1);
            end
          end
        end
        default: begin // S_RELEASE
          if (rs == '0) begin
            if (cnt_reg == DEB_LAST) begin
              cnt_reg      <= '0;
              dwell_reg    <= '0;
              col_reg      <= '0;
              key_held_reg <= 1'b0;
              state_reg    <= S_SCAN;
            end else begin
              cnt_reg <= cnt_reg + DBW'(1);
            end
          end else if (rs == pat_reg) begin
            // Key bounced back: resume holding without a new event.
            cnt_reg   <= '0;
            state_reg <= S_HOLD;
          end else begin
            cnt_reg <= '0;
          end
        end
      endcase
    end
  end

  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;
  assign key_code  = key_code_reg;
  assign key_class = key_class_reg;
  assign key_value = key_value_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
//   Randomized and directed bench for keypad_scan_ctrl (4x4). A keypad model
//   turns a pressed-key bitmap into row levels for the driven column. Expected
//   event times come from the scan rule: after reset/enable, column c is
//   sampled at the end of dwell c, so a stable key at column c fires
//   (c+1)*SCAN_DIV + DEB cycles later.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int SDIV = 8;
  localparam int DEB  = 8;
  localparam int REP  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] pressed = '0;
  logic [15:0] pressed_rep = '0;

  logic [3:0]  filas, filas_rep;
  logic [3:0]  columnas, columnas_rep;
  logic        key_valid, key_valid_rep;
  logic [3:0]  key_code, key_code_rep;
  logic [1:0]  key_class, key_class_rep;
  logic [3:0]  key_value, key_value_rep;
  logic        key_held, key_held_rep;

  int unsigned cyc = 0;
  int unsigned t0 = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int unsigned cyc;
    int          code;
    int          cls;
    int          value;
  } ev_t;
  ev_t ev_q[$];
  ev_t rep_q[$];

  string layout = "123A456B789C*0#D";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_scan_ctrl #(.ROWS(4), .COLS(4), .SCAN_DIV(SDIV), .DEBOUNCE_CYCLES(DEB),
                     .REPEAT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .filas(filas), .columnas(columnas),
    .key_valid(key_valid), .key_code(key_code), .key_class(key_class),
    .key_value(key_value), .key_held(key_held));

  keypad_scan_ctrl #(.ROWS(4), .COLS(4), .SCAN_DIV(SDIV), .DEBOUNCE_CYCLES(DEB),
                     .REPEAT_CYCLES(REP)) dut_rep (
    .clk(clk), .rst(rst), .enable(enable), .filas(filas_rep), .columnas(columnas_rep),
    .key_valid(key_valid_rep), .key_code(key_code_rep), .key_class(key_class_rep),
    .key_value(key_value_rep), .key_held(key_held_rep));

  // Keypad matrix: a pressed key connects its row to its column drive.
  always_comb begin
    filas = '0;
    filas_rep = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && columnas[c]) filas[r] = 1'b1;
        if (pressed_rep[r*4+c] && columnas_rep[c]) filas_rep[r] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid) begin
      ev_q.push_back('{cyc: cyc, code: key_code, cls: key_class, value: key_value});
      $display("event  t=%0d code=%0d class=%0d value=%0d", cyc - t0, key_code, key_class, key_value);
    end
    if (key_valid_rep) begin
      rep_q.push_back('{cyc: cyc, code: key_code_rep, cls: key_class_rep, value: key_value_rep});
      $display("repeat t=%0d code=%0d class=%0d value=%0d", cyc - t0, key_code_rep, key_class_rep, key_value_rep);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_class(input int k);
    byte ch = layout[k];
    if (ch >= "0" && ch <= "9") return 1;
    if (ch >= "A" && ch <= "D") return 2;
    return 3;
  endfunction

  function automatic int exp_value(input int k);
    byte ch = layout[k];
    if (ch >= "0" && ch <= "9") return ch - "0";
    if (ch >= "A" && ch <= "D") return ch - "A";
    return (ch == "#") ? 1 : 0;
  endfunction

  function automatic int latency(input int col);
    return (col + 1) * SDIV + DEB;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    ev_q.delete();
    rep_q.delete();
  endtask

  // Releases every key and measures cycles until key_held drops:
  // 2 synchroniser cycles + 1 detect cycle + DEB release cycles.
  task automatic release_and_check(input string tag);
    int n = 0;
    pressed = '0;
    while (key_held && n < 100) begin
      step(1);
      n++;
    end
    check_eq({tag, "_held_fall"}, n, DEB + 3);
  endtask

  task automatic check_event(input string tag, input int idx, input int k, input int unsigned t_exp);
    if (ev_q.size() > idx) begin
      check_eq({tag, "_time"},  ev_q[idx].cyc - t0, t_exp);
      check_eq({tag, "_code"},  ev_q[idx].code, k);
      check_eq({tag, "_class"}, ev_q[idx].cls, exp_class(k));
      check_eq({tag, "_value"}, ev_q[idx].value, exp_value(k));
    end else begin
      check_eq({tag, "_present"}, ev_q.size(), idx + 1);
    end
  endtask

  initial begin
    int k;
    int c;
    int h;
    int unsigned t_st;

    // Reset state
    step(2);
    check_eq("rst_columnas", columnas, 1);
    check_eq("rst_valid", key_valid, 0);
    check_eq("rst_code", key_code, 0);
    check_eq("rst_class", key_class, 0);
    check_eq("rst_value", key_value, 0);
    check_eq("rst_held", key_held, 0);

    // Steady key '5'
    pressed = 16'h0020;
    do_reset();
    wait_until(t0 + latency(1) + 30);
    check_eq("k5_count", ev_q.size(), 1);
    check_event("k5", 0, 5, latency(1));
    check_eq("k5_held", key_held, 1);
    release_and_check("k5");
    step(60);
    check_eq("k5_no_more", ev_q.size(), 1);
    check_eq("k5_code_kept", key_code, 5);

    // Randomized single-key presses
    for (int trial = 0; trial < 8; trial++) begin
      k = $urandom_range(0, 15);
      c = k % 4;
      h = $urandom_range(2, 60);
      pressed = '0;
      pressed[k] = 1'b1;
      do_reset();
      wait_until(t0 + latency(c) + h);
      check_eq("rnd_count", ev_q.size(), 1);
      check_event("rnd", 0, k, latency(c));
      check_eq("rnd_held", key_held, 1);
      release_and_check("rnd");
      step(50);
      check_eq("rnd_after_release", ev_q.size(), 1);
    end

    // Bounce on '#'
    pressed = '0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      pressed[14] = ((i / 3) % 2) == 0;
      step(1);
    end
    pressed[14] = 1'b1;
    t_st = cyc;
    check_eq("bounce_quiet", ev_q.size(), 0);
    while (ev_q.size() == 0 && cyc < t_st + 200) step(1);
    step(40);
    check_eq("bounce_count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check_eq("bounce_after_stable", ev_q[0].cyc >= t_st, 1);
      check_eq("bounce_code", ev_q[0].code, 14);
      check_eq("bounce_class", ev_q[0].cls, 3);
      check_eq("bounce_value", ev_q[0].value, 1);
    end
    release_and_check("bounce");

    // Two rows on column 3: no event, scan keeps wrapping
    pressed = 16'h0808;
    do_reset();
    for (int j = 0; j < 12; j++) begin
      wait_until(t0 + j * SDIV + 4);
      check_eq("multi_col", columnas, 1 << (j % 4));
    end
    check_eq("multi_no_event", ev_q.size(), 0);
    check_eq("multi_held", key_held, 0);
    pressed = '0;

    // Auto-repeat on 'D'
    pressed_rep = 16'h8000;
    do_reset();
    wait_until(t0 + latency(3) + 90);
    pressed_rep = '0;
    step(40);
    check_eq("rep_count", rep_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (rep_q.size() > i) begin
        check_eq("rep_time", rep_q[i].cyc - t0, latency(3) + i * REP);
        check_eq("rep_code", rep_q[i].code, 15);
        check_eq("rep_class", rep_q[i].cls, 2);
        check_eq("rep_value", rep_q[i].value, 3);
      end
    end
    check_eq("rep_held_fall", key_held_rep, 0);

    // Reset 4 cycles into debounce of '5'
    pressed = 16'h0020;
    do_reset();
    wait_until(t0 + 2 * SDIV + 4);
    rst = 1'b1;
    #1;
    check_eq("rstmid_columnas", columnas, 1);
    check_eq("rstmid_valid", key_valid, 0);
    check_eq("rstmid_held", key_held, 0);
    check_eq("rstmid_code", key_code, 0);
    step(3);
    check_eq("rstmid_no_event", ev_q.size(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    wait_until(t0 + latency(1) + 20);
    check_eq("rstmid_count", ev_q.size(), 1);
    check_event("rstmid", 0, 5, latency(1));

    // Enable dropped while holding '5'
    step(10);
    enable = 1'b0;
    #1;
    check_eq("en_columnas", columnas, 0);
    step(1);
    check_eq("en_held", key_held, 0);
    step(30);
    check_eq("en_no_event", ev_q.size(), 1);
    check_eq("en_code_kept", key_code, 5);
    enable = 1'b1;
    t0 = cyc;
    ev_q.delete();
    wait_until(t0 + latency(1) + 20);
    check_eq("en_count", ev_q.size(), 1);
    check_event("en", 0, 5, latency(1));
    release_and_check("en");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
